// File: rtl/seg_scan_scheduler.sv
// Handshake-paced scan scheduler for an 8-digit seven-segment display driven over an HC595 link.
// Each digit is encoded into a 16-bit shift word, sent with a start/busy handshake, then held lit.
module seg_scan_scheduler #(
    parameter int unsigned DIGIT_HOLD   = 50000,
    parameter int unsigned BUSY_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [31:0] display_data,
    input  logic        lz_blank,
    input  logic [7:0]  dp_mask,
    input  logic        drv_busy,
    output logic        drv_start,
    output logic [15:0] drv_data,
    output logic [2:0]  digit_idx,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam int unsigned HOLD_W = 24;
    localparam int unsigned TO_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DIGIT_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_HOLD      = 3'd5;

    logic [2:0]        state,        state_nx;
    logic [31:0]       snapshot,     snapshot_nx;
    logic [HOLD_W-1:0] hold_cnt,     hold_cnt_nx;
    logic [TO_W-1:0]   to_cnt,       to_cnt_nx;
    logic              drv_start_nx;
    logic [15:0]       drv_data_nx;
    logic [2:0]        digit_idx_nx;
    logic              frame_done_nx;
    logic              timeout_err_nx;

    // Hex nibble to active-low gfedcba segment pattern.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Build {dp_n, seg, sel}; a digit is a leading zero when it and every higher nibble are zero.
    function automatic logic [15:0] encode_digit(
        input logic [31:0] src,
        input logic [2:0]  k,
        input logic        lz,
        input logic [7:0]  dp
    );
        logic [31:0] upper;
        logic        blank;
        logic [6:0]  seg;
        logic [7:0]  sel;
        upper = src >> {k, 2'b00};
        blank = lz && (k != 3'd0) && (upper == 32'd0);
        seg   = blank ? 7'h7F : hex_seg(upper[3:0]);
        sel   = ~(8'b1 << k);
        return {~dp[k], seg, sel};
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            snapshot    <= '0;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            drv_start   <= 1'b0;
            drv_data    <= 16'hFFFF;
            digit_idx   <= 3'd0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            snapshot    <= snapshot_nx;
            hold_cnt    <= hold_cnt_nx;
            to_cnt      <= to_cnt_nx;
            drv_start   <= drv_start_nx;
            drv_data    <= drv_data_nx;
            digit_idx   <= digit_idx_nx;
            frame_done  <= frame_done_nx;
            timeout_err <= timeout_err_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx       = state;
        snapshot_nx    = snapshot;
        hold_cnt_nx    = hold_cnt;
        to_cnt_nx      = to_cnt;
        drv_start_nx   = 1'b0;
        drv_data_nx    = drv_data;
        digit_idx_nx   = digit_idx;
        frame_done_nx  = 1'b0;
        timeout_err_nx = timeout_err;

        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nx = S_LOAD;
                end
            end

            S_LOAD: begin
                // The snapshot is only refreshed at the start of a frame so a frame never tears.
                if (digit_idx == 3'd0) begin
                    snapshot_nx = display_data;
                end
                drv_data_nx = encode_digit(snapshot_nx, digit_idx, lz_blank, dp_mask);
                state_nx    = S_SEND;
            end

            S_SEND: begin
                if (!drv_busy) begin
                    drv_start_nx = 1'b1;
                    to_cnt_nx    = '0;
                    state_nx     = S_WAIT_ACK;
                end
            end

            S_WAIT_ACK: begin
                if (drv_busy) begin
                    state_nx = S_WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    timeout_err_nx = 1'b1;
                    hold_cnt_nx    = HOLD_LAST;
                    state_nx       = S_HOLD;
                end else begin
                    to_cnt_nx = to_cnt + 1'b1;
                end
            end

            S_WAIT_DONE: begin
                if (!drv_busy) begin
                    hold_cnt_nx = HOLD_LAST;
                    state_nx    = S_HOLD;
                end
            end

            S_HOLD: begin
                if (hold_cnt == '0) begin
                    frame_done_nx = (digit_idx == 3'd7);
                    digit_idx_nx  = digit_idx + 3'd1;
                    state_nx      = en ? S_LOAD : S_IDLE;
                end else begin
                    hold_cnt_nx = hold_cnt - 1'b1;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
